// File: rtl/ram_pkg.sv
// ram_pkg: shared types and the lane-merge helper for the ram_dp_be storage block.
//   ram_state_t  - CLEAR (post-reset fill sweep) / RUN (ports live)
//   rdw_mode_t   - same-address read-during-write result selection
//   byte_merge   - replaces the bits of old_word selected by an expanded
//                  bit mask with new_word; used by the write path and by
//                  the new-data read bypass so both agree bit for bit.
package ram_pkg;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} ram_state_t;

    typedef enum int {RDW_OLD = 0, RDW_NEW = 1} rdw_mode_t;

    // Widest word byte_merge can handle; callers zero-extend into it.
    localparam int MERGE_MAX_W = 1024;

    // mask is the lane enable expanded to one bit per data bit.
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_W-1:0] mask
    );
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// ram_read_pipe: data+valid delay line placed after the array read register.
//   clock, reset         - system clock, synchronous active-high reset
//   in_valid, in_data    - result from the array read register
//   out_valid, out_data  - result delayed by STAGES cycles (STAGES=0 is a wire)
// Each stage only loads data when valid travels with it, so out_data holds
// the last delivered result while out_valid is low.
module ram_read_pipe
    import ram_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [STAGES:0]  vld_pipe;
    logic [WIDTH-1:0] data_pipe [STAGES+1];

    assign vld_pipe[0]  = in_valid;
    assign data_pipe[0] = in_data;

    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        logic             vld_q, vld_d;
        logic [WIDTH-1:0] data_q, data_d;

        always_comb begin
            vld_d  = vld_pipe[s-1];
            data_d = vld_pipe[s-1] ? data_pipe[s-1] : data_q;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else begin
                vld_q  <= vld_d;
                data_q <= data_d;
            end
        end

        assign vld_pipe[s]  = vld_q;
        assign data_pipe[s] = data_q;
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_data  = data_pipe[STAGES];

endmodule

// File: rtl/ram_dp_be.sv
// ram_dp_be: simple dual-port synchronous RAM with byte-lane write enables.
//   clock, reset        - system clock, synchronous active-high reset
//   ready               - 1 once the post-reset clear sweep has filled the array
//   read_enable/address - read request; result on read_data with read_valid
//                         READ_LATENCY edges later (1 or 2)
//   write_enable, write_byte_enable, write_address, write_data
//                       - masked write port
// After reset the array is swept to INIT_VALUE, one word per edge; requests
// are dropped until the sweep completes. Out-of-range writes are ignored and
// out-of-range reads return 0 with read_valid=1.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int WIDTH_DATA   = 16,
    parameter int WIDTH_BYTE   = 8,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter logic [WIDTH_DATA-1:0] INIT_VALUE = '0,
    localparam int NUM_BYTES   = WIDTH_DATA / WIDTH_BYTE,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  read_enable,
    input  logic [AW-1:0]         read_address,
    output logic [WIDTH_DATA-1:0] read_data,
    output logic                  read_valid,
    input  logic                  write_enable,
    input  logic [NUM_BYTES-1:0]  write_byte_enable,
    input  logic [AW-1:0]         write_address,
    input  logic [WIDTH_DATA-1:0] write_data
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("ram_dp_be: READ_LATENCY must be 1 or 2");
    end
    if (WIDTH_DATA % WIDTH_BYTE != 0) begin : g_bad_width
        $error("ram_dp_be: WIDTH_DATA must be a multiple of WIDTH_BYTE");
    end
    if (WIDTH_DATA > MERGE_MAX_W) begin : g_too_wide
        $error("ram_dp_be: WIDTH_DATA exceeds byte_merge width");
    end

    localparam logic [AW:0]   DEPTH_X    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam int            PIPE_STAGE = (READ_LATENCY >= 2) ? READ_LATENCY - 1 : 0;

    logic [WIDTH_DATA-1:0] mem_q [DEPTH];

    ram_state_t            state_q, state_d;
    logic [AW-1:0]         clear_addr_q, clear_addr_d;
    logic                  ready_q, ready_d;
    logic                  s1_vld_q, s1_vld_d;
    logic [WIDTH_DATA-1:0] s1_data_q, s1_data_d;

    logic                  mem_we;
    logic [AW-1:0]         mem_wa;
    logic [WIDTH_DATA-1:0] mem_wd;

    logic [WIDTH_DATA-1:0] bit_mask;
    logic                  wr_in_range, rd_in_range;
    logic [AW-1:0]         wr_idx, rd_idx;
    logic [WIDTH_DATA-1:0] wr_word;
    logic                  wr_fire, rd_fire, rdw_hit;

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_mask
        assign bit_mask[i*WIDTH_BYTE +: WIDTH_BYTE] = {WIDTH_BYTE{write_byte_enable[i]}};
    end

    // Out-of-range addresses are steered to word 0 so the array is never
    // indexed past DEPTH; the in-range flags gate any effect.
    assign wr_in_range = {1'b0, write_address} < DEPTH_X;
    assign rd_in_range = {1'b0, read_address} < DEPTH_X;
    assign wr_idx      = wr_in_range ? write_address : '0;
    assign rd_idx      = rd_in_range ? read_address  : '0;

    assign wr_word = WIDTH_DATA'(byte_merge(MERGE_MAX_W'(mem_q[wr_idx]),
                                            MERGE_MAX_W'(write_data),
                                            MERGE_MAX_W'(bit_mask)));

    assign wr_fire = (state_q == RUN) && write_enable && wr_in_range && (|write_byte_enable);
    assign rd_fire = (state_q == RUN) && read_enable;
    assign rdw_hit = wr_fire && (write_address == read_address);

    // Single array write port, shared by the clear sweep and the user port.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = clear_addr_q;
        mem_wd = INIT_VALUE;
        if (state_q == CLEAR) begin
            mem_we = 1'b1;
        end else if (wr_fire) begin
            mem_we = 1'b1;
            mem_wa = write_address;
            mem_wd = wr_word;
        end
    end

    // The reset edge leaves the array contents alone.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        ready_d      = ready_q;
        if (state_q == CLEAR) begin
            if (clear_addr_q == LAST_ADDR) begin
                state_d = RUN;
                ready_d = 1'b1;
            end else begin
                clear_addr_d = clear_addr_q + 1'b1;
            end
        end
    end

    // Array read register. The array itself still holds the pre-write word
    // on a same-address collision, so old-data mode needs no special case.
    always_comb begin
        s1_vld_d  = rd_fire;
        s1_data_d = s1_data_q;
        if (rd_fire) begin
            if (!rd_in_range) begin
                s1_data_d = '0;
            end else if (RDW_MODE == RDW_NEW && rdw_hit) begin
                s1_data_d = wr_word;
            end else begin
                s1_data_d = mem_q[rd_idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CLEAR;
            clear_addr_q <= '0;
            ready_q      <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            ready_q      <= ready_d;
            s1_vld_q     <= s1_vld_d;
            s1_data_q    <= s1_data_d;
        end
    end

    assign ready = ready_q;

    ram_read_pipe #(
        .WIDTH  (WIDTH_DATA),
        .STAGES (PIPE_STAGE)
    ) u_read_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s1_vld_q),
        .in_data   (s1_data_q),
        .out_valid (read_valid),
        .out_data  (read_data)
    );

endmodule
